memoria_ctrl: RTL and testbench
===============================

# memoria_ctrl

Command-driven access sequencer that masters the 32×14 single-port `memoria` array, driving its write enable, address and write-data inputs and consuming its combinational read data. It accepts one block command at a time over a valid/ready handshake and executes it one word per cycle:
- FILL a range with a constant,
- SUM a range modulo 2^DW,
- COPY a range to another base address.

It sits between the control logic and `memoria`, so no other block drives the memory while it is busy.

## Interface
- `AW`, 5, address width; depth = 2^AW words.
- `DW`, 14, data word width.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE; a command is accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_op`  in  2  00 FILL, 01 SUM, 10 COPY, 11 illegal.
- `cmd_base`  in  AW  source/target start address.
- `cmd_dst`  in  AW  COPY destination start address; ignored otherwise.
- `cmd_count`  in  AW+1  number of words, 0..32.
- `cmd_fill`  in  DW  FILL value.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at command completion.
- `err`  out  1  high with `done` when the completed op was illegal; otherwise 0.
- `sum`  out  DW  SUM result; held until the next command is accepted.
- `mem_en`  out  1  memory write enable.
- `mem_address`  out  AW  memory address.
- `mem_datain`  out  DW  memory write data.
- `mem_dataout`  in  DW  memory read data; combinational from `mem_address`, valid in the same cycle.

## Operation
- States: IDLE, FILL, SUM, CP_RD, CP_WR, DONE.
- On accept, latch op, base, dst, count and fill; clear index `i` to 0.
  - If op is SUM, clear the accumulator.
  - Next state is the op state (FILL / SUM / CP_RD).
  - If count == 0 or op == 11, next state is DONE.
- FILL: `mem_en=1`, `mem_address=base+i`, `mem_datain=fill`. Increment `i`; after word count-1, go to DONE.
- SUM: `mem_en=0`, `mem_address=base+i`; `acc <= acc + mem_dataout`, truncated to DW bits (mod 2^14). Increment `i`; after the last word, go to DONE.
- COPY, two cycles per word:
  - CP_RD: `mem_address=base+i`, `mem_en=0`; capture `mem_dataout` into a hold register; go to CP_WR.
  - CP_WR: `mem_en=1`, `mem_address=dst+i`, `mem_datain=hold`; increment `i`; go to CP_RD, or to DONE after the last word.
- Address arithmetic: `base+i` and `dst+i` are computed mod 2^AW, so ranges wrap from 31 to 0.
- Overlap: COPY runs in ascending order. Word i is read before word i is written, and no buffering beyond one word is done. If dst lies inside (base, base+count), source words are overwritten before they are read. This is the defined behaviour, not an error.
- DONE: `done=1`; `err=1` if op was 11; `sum` updated from acc if op was SUM. Next state is IDLE.
- Outside FILL and CP_WR: `mem_en=0` and `mem_datain=0`. In IDLE and DONE: `mem_address=0`.
- Commands presented while busy are not accepted. `cmd_valid` must be held until accepted.

## Timing
- Reset values: state IDLE, `cmd_ready=1`, `busy=0`, `done=0`, `err=0`, `sum=0`, `mem_en=0`, `mem_address=0`, `mem_datain=0`.
- Asserting `rst_n` low mid-command forces IDLE and `mem_en=0` immediately (asynchronously). Words already written stay written; there is no rollback.
- Accept at edge k:
  - FILL/SUM: the op state occupies cycles k+1..k+count; `done` is high in cycle k+count+1; `cmd_ready` is high again in cycle k+count+2.
  - COPY: `done` is high in cycle k+2·count+1.
  - count 0 or illegal op: `done` is high in cycle k+1.
- Each memory write lands on the rising edge that ends the cycle in which `mem_en=1`.
- `sum` changes only on the edge that enters DONE for a SUM op.

## Test plan
- **FILL:** FILL base=30, count=4, fill=0x2AB → writes hit addresses 30, 31, 0, 1 on 4 consecutive edges; `done` is high 5 cycles after accept; `mem_en` is high for exactly 4 cycles.
- **SUM wrap:** preload addresses 0..3 = 0x3FFF, 0x0001, 0x1000, 0x0002 → SUM base=0, count=4 gives `sum=0x1002`, `err=0`.
- **COPY overlap:** preload 0..4 = 1..5 → COPY base=0, dst=1, count=3 leaves mem[1..3] = 1, 1, 1 (forward overwrite); `done` is high 7 cycles after accept.
- **Zero count / illegal op:** SUM count=0 → `done` next cycle and `sum=0`. Then `cmd_op=11`, count=5 → `done=err=1` next cycle, no memory write, `sum` unchanged.
- **Back-to-back commands:** hold `cmd_valid` through a FILL → `cmd_ready=0` while busy, and the second command is accepted the first IDLE cycle after `done`.
- **Mid-command reset:** pull `rst_n` low during the 3rd word of FILL count=8 → `mem_en` drops immediately and only 2 words are written. After release, a new command completes normally.

Source files
------------

// File: rtl/memoria_ctrl_if.sv
// Command and memory-port bundle for memoria_ctrl.
// The slave view belongs to the sequencer; the master view to the command source and memory.
interface memoria_ctrl_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 14
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_base;
  logic [AW-1:0] cmd_dst;
  logic [AW:0]   cmd_count;
  logic [DW-1:0] cmd_fill;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] sum;
  logic          mem_en;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_datain;
  logic [DW-1:0] mem_dataout;

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_dst, cmd_count, cmd_fill, mem_dataout,
    output cmd_ready, busy, done, err, sum, mem_en, mem_address, mem_datain
  );

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_dst, cmd_count, cmd_fill, mem_dataout,
    input  cmd_ready, busy, done, err, sum, mem_en, mem_address, mem_datain
  );
endinterface

// File: rtl/memoria_ctrl.sv
// Block-command sequencer for the single-port memoria array: FILL, SUM and COPY, one word per cycle.
// Every output is registered; output registers load the values implied by the next state.
module memoria_ctrl #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  memoria_ctrl_if.slave  bus
);
  localparam int unsigned CW = AW + 1;
  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_SUM  = 2'b01;
  localparam logic [1:0] OP_ILL  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_SUM, S_CP_RD, S_CP_WR, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_op, w_op_nxt;
  logic [AW-1:0] r_base, w_base_nxt;
  logic [AW-1:0] r_dst, w_dst_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [CW-1:0] r_i, w_i_nxt;
  logic [DW-1:0] r_fill, w_fill_nxt;
  logic [DW-1:0] r_acc, w_acc_nxt;
  logic [DW-1:0] r_hold, w_hold_nxt;
  logic [DW-1:0] r_sum, w_sum_nxt;
  logic          r_cmd_ready, w_cmd_ready_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic          r_mem_en, w_mem_en_nxt;
  logic [AW-1:0] r_mem_address, w_mem_address_nxt;
  logic [DW-1:0] r_mem_datain, w_mem_datain_nxt;
  logic          w_last;

  assign w_last = ((r_i + CW'(1)) == r_count);

  // Next-state, datapath and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_op_nxt          = r_op;
    w_base_nxt        = r_base;
    w_dst_nxt         = r_dst;
    w_count_nxt       = r_count;
    w_i_nxt           = r_i;
    w_fill_nxt        = r_fill;
    w_acc_nxt         = r_acc;
    w_hold_nxt        = r_hold;
    w_sum_nxt         = r_sum;
    w_mem_en_nxt      = 1'b0;
    w_mem_address_nxt = '0;
    w_mem_datain_nxt  = '0;

    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_op_nxt    = bus.cmd_op;
          w_base_nxt  = bus.cmd_base;
          w_dst_nxt   = bus.cmd_dst;
          w_count_nxt = bus.cmd_count;
          w_fill_nxt  = bus.cmd_fill;
          w_i_nxt     = '0;
          if (bus.cmd_op == OP_SUM) w_acc_nxt = '0;
          if ((bus.cmd_count == '0) || (bus.cmd_op == OP_ILL)) begin
            w_state_nxt = S_DONE;
          end else begin
            case (bus.cmd_op)
              OP_FILL: w_state_nxt = S_FILL;
              OP_SUM:  w_state_nxt = S_SUM;
              default: w_state_nxt = S_CP_RD;
            endcase
          end
        end
      end
      S_FILL: begin
        w_i_nxt = r_i + CW'(1);
        if (w_last) w_state_nxt = S_DONE;
      end
      S_SUM: begin
        w_acc_nxt = r_acc + bus.mem_dataout;
        w_i_nxt   = r_i + CW'(1);
        if (w_last) w_state_nxt = S_DONE;
      end
      S_CP_RD: begin
        w_hold_nxt  = bus.mem_dataout;
        w_state_nxt = S_CP_WR;
      end
      S_CP_WR: begin
        w_i_nxt     = r_i + CW'(1);
        w_state_nxt = w_last ? S_DONE : S_CP_RD;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // sum moves only on the edge entering DONE for a SUM command
    if ((w_state_nxt == S_DONE) && (w_op_nxt == OP_SUM)) w_sum_nxt = w_acc_nxt;

    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_done_nxt      = (w_state_nxt == S_DONE);
    w_err_nxt       = (w_state_nxt == S_DONE) && (w_op_nxt == OP_ILL);

    // Memory port for the cycle about to start; addresses wrap mod 2^AW
    case (w_state_nxt)
      S_FILL: begin
        w_mem_en_nxt      = 1'b1;
        w_mem_address_nxt = w_base_nxt + w_i_nxt[AW-1:0];
        w_mem_datain_nxt  = w_fill_nxt;
      end
      S_SUM, S_CP_RD: w_mem_address_nxt = w_base_nxt + w_i_nxt[AW-1:0];
      S_CP_WR: begin
        w_mem_en_nxt      = 1'b1;
        w_mem_address_nxt = w_dst_nxt + w_i_nxt[AW-1:0];
        w_mem_datain_nxt  = w_hold_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_base        <= '0;
      r_dst         <= '0;
      r_count       <= '0;
      r_i           <= '0;
      r_fill        <= '0;
      r_acc         <= '0;
      r_hold        <= '0;
      r_sum         <= '0;
      r_cmd_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_address <= '0;
      r_mem_datain  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_op          <= w_op_nxt;
      r_base        <= w_base_nxt;
      r_dst         <= w_dst_nxt;
      r_count       <= w_count_nxt;
      r_i           <= w_i_nxt;
      r_fill        <= w_fill_nxt;
      r_acc         <= w_acc_nxt;
      r_hold        <= w_hold_nxt;
      r_sum         <= w_sum_nxt;
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
      r_mem_en      <= w_mem_en_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_mem_datain  <= w_mem_datain_nxt;
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.sum         = r_sum;
  assign bus.mem_en      = r_mem_en;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_datain  = r_mem_datain;
endmodule

// File: tb/tb_memoria_ctrl.sv
// Bench for memoria_ctrl: behavioural memoria array, reference memory image and a done-time scoreboard.
module tb_memoria_ctrl;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 14;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned NV = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memoria_ctrl_if #(.AW(AW), .DW(DW)) bus ();
  memoria_ctrl #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // memoria model; the pl_* port lets the bench preload words while the DUT is idle
  logic [DW-1:0] dut_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) dut_mem[pl_addr] <= pl_data;
    else if (bus.mem_en) dut_mem[bus.mem_address] <= bus.mem_datain;
  end
  assign bus.mem_dataout = dut_mem[bus.mem_address];

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   acc_cyc;
    int unsigned   lat;
    logic          err;
    logic [DW-1:0] sum;
    int unsigned   wr;
  } exp_t;

  typedef struct {
    int            pre;
    logic [1:0]    op;
    logic [AW-1:0] base;
    logic [AW-1:0] dst;
    logic [CW-1:0] cnt;
    logic [DW-1:0] fill;
    int unsigned   lat;
    logic          err;
    logic [DW-1:0] sum;
    int unsigned   wr;
  } vec_t;

  exp_t        sbq [$];
  vec_t        vt [NV];
  int          checks;
  int          errors;
  int unsigned wr_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Scoreboard consumer: each done pulse pops the oldest outstanding command
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      wr_cnt = 0;
    end else begin
      if (bus.mem_en) wr_cnt++;
      if (bus.done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected actual=1 required=0 at cycle %0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk("latency", cyc - e.acc_cyc, e.lat);
          chk("err", 32'(bus.err), 32'(e.err));
          chk("sum", 32'(bus.sum), 32'(e.sum));
          chk("writes", wr_cnt, e.wr);
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic model(input logic [1:0] op, input logic [AW-1:0] base, input logic [AW-1:0] dst,
                       input logic [CW-1:0] cnt, input logic [DW-1:0] fill);
    for (int j = 0; j < int'(cnt); j++) begin
      if (op == 2'b00) ref_mem[AW'(int'(base) + j)] = fill;
      else if (op == 2'b10) ref_mem[AW'(int'(dst) + j)] = ref_mem[AW'(int'(base) + j)];
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [AW-1:0] base, input logic [AW-1:0] dst,
                      input logic [CW-1:0] cnt, input logic [DW-1:0] fill, input int unsigned lat,
                      input logic err, input logic [DW-1:0] sum, input int unsigned wr);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.cmd_op = op; bus.cmd_base = base; bus.cmd_dst = dst;
    bus.cmd_count = cnt; bus.cmd_fill = fill; bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_ready required=ready");
    end
    e.acc_cyc = cyc; e.lat = lat; e.err = err; e.sum = sum; e.wr = wr;
    sbq.push_back(e);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    model(op, base, dst, cnt, fill);
  endtask

  // Wait for all outstanding commands to finish, then compare the whole memory image
  task automatic wait_idle(input string tag);
    int n;
    int bad;
    int first;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout actual=pending%0d required=pending0", tag, sbq.size());
      sbq.delete();
    end
    bad = 0;
    first = -1;
    for (int a = 0; a < int'(DEPTH); a++) begin
      if (dut_mem[a] !== ref_mem[a]) begin
        bad++;
        if (first < 0) first = a;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_mem_image actual=%0d_bad_words(first addr %0d = 0x%0h) required=0x%0h",
               tag, bad, first, dut_mem[first], ref_mem[first]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] spre [4];
    spre[0] = 14'h3FFF; spre[1] = 14'h0001; spre[2] = 14'h1000; spre[3] = 14'h0002;

    //          pre op     base   dst    cnt     fill     lat err  sum       wr
    vt[0] = '{1, 2'b01, 5'd0,  5'd0, 6'd4,  14'h000, 5,  1'b0, 14'h1002, 0};
    vt[1] = '{0, 2'b00, 5'd30, 5'd0, 6'd4,  14'h2AB, 5,  1'b0, 14'h1002, 4};
    vt[2] = '{2, 2'b10, 5'd0,  5'd1, 6'd3,  14'h000, 7,  1'b0, 14'h1002, 3};
    vt[3] = '{0, 2'b01, 5'd5,  5'd0, 6'd0,  14'h000, 1,  1'b0, 14'h0000, 0};
    vt[4] = '{0, 2'b11, 5'd3,  5'd9, 6'd5,  14'h111, 1,  1'b1, 14'h0000, 0};
    vt[5] = '{0, 2'b01, 5'd0,  5'd0, 6'd5,  14'h000, 6,  1'b0, 14'h0009, 0};
    vt[6] = '{0, 2'b10, 5'd30, 5'd2, 6'd4,  14'h000, 9,  1'b0, 14'h0009, 4};
    vt[7] = '{0, 2'b01, 5'd30, 5'd0, 6'd8,  14'h000, 9,  1'b0, 14'h0AB0, 0};
    vt[8] = '{0, 2'b00, 5'd7,  5'd0, 6'd32, 14'h155, 33, 1'b0, 14'h0AB0, 32};
    vt[9] = '{0, 2'b01, 5'd0,  5'd0, 6'd32, 14'h000, 33, 1'b0, 14'h2AA0, 0};

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_base = '0; bus.cmd_dst = '0;
    bus.cmd_count = '0; bus.cmd_fill = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    rst_n = 1'b0;
    for (int a = 0; a < int'(DEPTH); a++) preload(AW'(a), '0);

    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
    chk("rst_mem_datain", 32'(bus.mem_datain), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < int'(NV); v++) begin
      if (vt[v].pre == 1) for (int a = 0; a < 4; a++) preload(AW'(a), spre[a]);
      if (vt[v].pre == 2) for (int a = 0; a < 5; a++) preload(AW'(a), DW'(a + 1));
      send(vt[v].op, vt[v].base, vt[v].dst, vt[v].cnt, vt[v].fill,
           vt[v].lat, vt[v].err, vt[v].sum, vt[v].wr);
      wait_idle($sformatf("vec%0d", v));
    end

    // Back-to-back: cmd_valid held through a FILL, SUM queued behind it
    begin
      exp_t e;
      int   c;
      int   rdy_seen;
      @(negedge clk);
      bus.cmd_op = 2'b00; bus.cmd_base = 5'd10; bus.cmd_dst = '0;
      bus.cmd_count = 6'd3; bus.cmd_fill = 14'h0AA; bus.cmd_valid = 1'b1;
      c = int'(cyc);
      e.acc_cyc = cyc; e.lat = 4; e.err = 1'b0; e.sum = 14'h2AA0; e.wr = 3;
      sbq.push_back(e);
      @(posedge clk);
      #1 bus.cmd_op = 2'b01;
      model(2'b00, 5'd10, 5'd0, 6'd3, 14'h0AA);
      e.acc_cyc = 32'(c + 5); e.lat = 4; e.err = 1'b0; e.sum = 14'h01FE; e.wr = 0;
      sbq.push_back(e);
      rdy_seen = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (bus.cmd_ready || !bus.busy) rdy_seen++;
      end
      chk("b2b_ready_while_busy", 32'(rdy_seen), 32'd0);
      @(negedge clk);
      chk("b2b_ready_first_idle", 32'(bus.cmd_ready), 32'd1);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      wait_idle("b2b");
    end

    // Reset pulled during the third word of FILL count=8
    @(negedge clk);
    bus.cmd_op = 2'b00; bus.cmd_base = 5'd20; bus.cmd_count = 6'd8;
    bus.cmd_fill = 14'h3C3; bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("midrst_sum", 32'(bus.sum), 32'd0);
    ref_mem[20] = 14'h3C3;
    ref_mem[21] = 14'h3C3;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle("midrst");
    send(2'b01, 5'd20, 5'd0, 6'd3, 14'h000, 4, 1'b0, 14'h08DB, 0);
    wait_idle("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
